// File: rtl/lf_pkg.sv
// lf_pkg: shared types, pin encodings and sensor classification for the line follower.
package lf_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FOLLOW, S_TURN_R, S_TURN_L, S_NODE, S_LOST} state_t;
  typedef enum logic [1:0] {C_OFF, C_MID, C_ON} cls_t;
  localparam logic [1:0] DIR_FWD  = 2'b10;
  localparam logic [1:0] DIR_REV  = 2'b01;
  localparam logic [1:0] DIR_STOP = 2'b00;
  function automatic cls_t classify(input int unsigned s, input int unsigned hi, input int unsigned lo);
    return (s > hi) ? C_ON : (s < lo) ? C_OFF : C_MID;
  endfunction
endpackage

// File: rtl/lf_sample_counter.sv
// lf_sample_counter: saturating count of consecutive valid samples carrying an event.
module lf_sample_counter #(
  parameter int LIM = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic valid,
  input  logic ev,
  output logic hit
);
  localparam int W = $clog2(LIM + 1);
  localparam logic [W-1:0] TOP = W'(LIM);
  logic [W-1:0] count;
  // hit flags the sample that brings the count to its limit
  assign hit = valid && ev && (count >= TOP - 1'b1);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (valid) count <= !ev ? '0 : (count == TOP) ? count : count + 1'b1;
endmodule

// File: rtl/line_follower_fsm.sv
// line_follower_fsm: three-sensor line follower with node counting and lost-line stop.
module line_follower_fsm
  import lf_pkg::*;
#(
  parameter int          ADC_W      = 12,
  parameter int unsigned HI_THR     = 1000,
  parameter int unsigned LO_THR     = 200,
  parameter int          DC_W       = 4,
  parameter int          NODE_W     = 4,
  parameter int          NODE_DEB   = 3,
  parameter int          LOST_LIM   = 8,
  parameter logic [DC_W-1:0] DC_FWD     = DC_W'(4),
  parameter logic [DC_W-1:0] DC_TURN_HI = DC_W'(7),
  parameter logic [DC_W-1:0] DC_TURN_LO = DC_W'(3),
  parameter logic [DC_W-1:0] DC_NODE_HI = DC_W'(9),
  parameter logic [DC_W-1:0] DC_NODE_LO = DC_W'(5)
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  left,
  input  logic [ADC_W-1:0]  middle,
  input  logic [ADC_W-1:0]  right,
  output logic              m1_a,
  output logic              m1_b,
  output logic              m2_a,
  output logic              m2_b,
  output logic [DC_W-1:0]   dc1,
  output logic [DC_W-1:0]   dc2,
  output logic              node_flag,
  output logic              node_pulse,
  output logic [NODE_W-1:0] node_count,
  output logic              lost_line
);
  cls_t cl, cm, cr;
  state_t state, state_nx;
  logic all_on, all_off, any_on, centered, node_hit, lost_hit, declare;
  logic [1:0] m1_nx, m2_nx;
  logic [DC_W-1:0] dc1_nx, dc2_nx;

  assign cl = classify(32'(left), HI_THR, LO_THR);
  assign cm = classify(32'(middle), HI_THR, LO_THR);
  assign cr = classify(32'(right), HI_THR, LO_THR);
  assign all_on   = cl == C_ON && cm == C_ON && cr == C_ON;
  assign all_off  = cl == C_OFF && cm == C_OFF && cr == C_OFF;
  assign any_on   = cl == C_ON || cm == C_ON || cr == C_ON;
  assign centered = cl == C_OFF && cm == C_ON && cr == C_OFF;

  lf_sample_counter #(.LIM(NODE_DEB)) u_node_deb (
    .clk(clk_50M), .rst(rst), .clr(!enable), .valid(sample_valid), .ev(all_on), .hit(node_hit)
  );
  lf_sample_counter #(.LIM(LOST_LIM)) u_lost (
    .clk(clk_50M), .rst(rst), .clr(!enable), .valid(sample_valid), .ev(all_off), .hit(lost_hit)
  );

  always_comb begin
    state_nx = state;
    declare  = 1'b0;
    if (!enable) state_nx = S_IDLE;
    else if (sample_valid)
      case (state)
        S_IDLE: state_nx = S_FOLLOW;
        S_NODE: state_nx = centered ? S_FOLLOW : S_NODE;
        S_LOST: state_nx = any_on ? S_FOLLOW : S_LOST;
        default: begin
          declare  = node_hit;
          state_nx = node_hit ? S_NODE :
                     lost_hit ? S_LOST :
                     (cr == C_ON && cl == C_OFF) ? S_TURN_R :
                     (cl == C_ON && cr == C_OFF) ? S_TURN_L :
                     centered ? S_FOLLOW : state;
        end
      endcase
  end

  // outputs are decoded from the next state so they land in registers
  always_comb begin
    m1_nx  = (state_nx inside {S_FOLLOW, S_TURN_R, S_NODE}) ? DIR_FWD :
             (state_nx == S_TURN_L) ? DIR_REV : DIR_STOP;
    m2_nx  = (state_nx inside {S_FOLLOW, S_TURN_L}) ? DIR_FWD :
             (state_nx inside {S_TURN_R, S_NODE}) ? DIR_REV : DIR_STOP;
    dc1_nx = (state_nx == S_FOLLOW) ? DC_FWD : (state_nx == S_TURN_R) ? DC_TURN_HI :
             (state_nx == S_TURN_L) ? DC_TURN_LO : (state_nx == S_NODE) ? DC_NODE_HI : '0;
    dc2_nx = (state_nx == S_FOLLOW) ? DC_FWD : (state_nx == S_TURN_R) ? DC_TURN_LO :
             (state_nx == S_TURN_L) ? DC_TURN_HI : (state_nx == S_NODE) ? DC_NODE_LO : '0;
  end

  always_ff @(posedge clk_50M or posedge rst)
    if (rst) begin
      state        <= S_IDLE;
      {m1_a, m1_b} <= DIR_STOP;
      {m2_a, m2_b} <= DIR_STOP;
      dc1          <= '0;
      dc2          <= '0;
      node_flag    <= 1'b0;
      node_pulse   <= 1'b0;
      node_count   <= '0;
      lost_line    <= 1'b0;
    end else begin
      state        <= state_nx;
      {m1_a, m1_b} <= m1_nx;
      {m2_a, m2_b} <= m2_nx;
      dc1          <= dc1_nx;
      dc2          <= dc2_nx;
      node_flag    <= state_nx == S_NODE;
      node_pulse   <= declare;
      node_count   <= node_count + NODE_W'(declare);
      lost_line    <= state_nx == S_LOST;
    end
endmodule

// File: tb/tb_line_follower_fsm.sv
// tb_line_follower_fsm: table-driven scoreboard bench for line_follower_fsm.
module tb_line_follower_fsm;
  typedef struct packed {
    logic [3:0] pins;
    logic [3:0] dc1;
    logic [3:0] dc2;
    logic       flag;
    logic       pulse;
    logic [3:0] cnt;
    logic       lost;
  } exp_t;
  typedef struct {
    logic [11:0] l, m, r;
    exp_t        e;
  } vec_t;

  logic clk_50M = 1'b0;
  logic rst = 1'b1, enable = 1'b0, sample_valid = 1'b0;
  logic [11:0] left = '0, middle = '0, right = '0;
  logic m1_a, m1_b, m2_a, m2_b, node_flag, node_pulse, lost_line;
  logic [3:0] dc1, dc2, node_count;
  int n_cmp = 0, n_fail = 0;
  exp_t sb[$];
  vec_t tbl[$];
  logic [3:0] exp_cnt;

  always #10 clk_50M = ~clk_50M;

  line_follower_fsm dut (
    .clk_50M(clk_50M), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .left(left), .middle(middle), .right(right),
    .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b), .dc1(dc1), .dc2(dc2),
    .node_flag(node_flag), .node_pulse(node_pulse), .node_count(node_count), .lost_line(lost_line)
  );

  function automatic exp_t ex(logic [3:0] p, logic [3:0] a, logic [3:0] b, logic f, logic pu, logic [3:0] c, logic l);
    return exp_t'({p, a, b, f, pu, c, l});
  endfunction
  function automatic exp_t fol(logic [3:0] c); return ex(4'b1010, 4'd4, 4'd4, 1'b0, 1'b0, c, 1'b0); endfunction
  function automatic exp_t tr(logic [3:0] c);  return ex(4'b1001, 4'd7, 4'd3, 1'b0, 1'b0, c, 1'b0); endfunction
  function automatic exp_t tl(logic [3:0] c);  return ex(4'b0110, 4'd3, 4'd7, 1'b0, 1'b0, c, 1'b0); endfunction
  function automatic exp_t nd(logic [3:0] c, logic pu); return ex(4'b1001, 4'd9, 4'd5, 1'b1, pu, c, 1'b0); endfunction
  function automatic exp_t st(logic [3:0] c, logic l);  return ex(4'b0000, 4'd0, 4'd0, 1'b0, 1'b0, c, l); endfunction
  function automatic vec_t mv(logic [11:0] l, logic [11:0] m, logic [11:0] r, exp_t e);
    vec_t v;
    v.l = l; v.m = m; v.r = r; v.e = e;
    return v;
  endfunction

  task automatic check(input string nm);
    exp_t a, e;
    a = exp_t'({m1_a, m1_b, m2_a, m2_b, dc1, dc2, node_flag, node_pulse, node_count, lost_line});
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got pins=%b dc=%0d/%0d flag=%b pulse=%b cnt=%0d lost=%b, want pins=%b dc=%0d/%0d flag=%b pulse=%b cnt=%0d lost=%b",
               nm, a.pins, a.dc1, a.dc2, a.flag, a.pulse, a.cnt, a.lost,
               e.pins, e.dc1, e.dc2, e.flag, e.pulse, e.cnt, e.lost);
    end
  endtask

  task automatic smp(input logic [11:0] l, input logic [11:0] m, input logic [11:0] r, input exp_t e, input string nm);
    left = l; middle = m; right = r; sample_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk_50M);
    sample_valid = 1'b0;
    check(nm);
  endtask

  task automatic idle(input exp_t e, input string nm);
    sb.push_back(e);
    @(negedge clk_50M);
    check(nm);
  endtask

  initial begin
    tbl.push_back(mv(100, 2000, 100, fol(0)));
    tbl.push_back(mv(100, 500, 3000, tr(0)));
    tbl.push_back(mv(3000, 500, 100, tl(0)));
    tbl.push_back(mv(500, 500, 500, tl(0)));
    tbl.push_back(mv(100, 2000, 100, fol(0)));
    tbl.push_back(mv(2000, 2000, 2000, fol(0)));
    tbl.push_back(mv(2000, 2000, 2000, fol(0)));
    tbl.push_back(mv(100, 2000, 100, fol(0)));
    tbl.push_back(mv(2000, 2000, 2000, fol(0)));
    tbl.push_back(mv(2000, 2000, 2000, fol(0)));
    tbl.push_back(mv(2000, 2000, 2000, nd(1, 1)));
    tbl.push_back(mv(2000, 2000, 2000, nd(1, 0)));
    tbl.push_back(mv(3000, 500, 100, nd(1, 0)));
    tbl.push_back(mv(100, 2000, 100, fol(1)));
    tbl.push_back(mv(1000, 2000, 200, fol(1)));
    tbl.push_back(mv(199, 500, 1001, tr(1)));
    tbl.push_back(mv(200, 500, 1001, tr(1)));
    tbl.push_back(mv(1001, 500, 199, tl(1)));
    tbl.push_back(mv(100, 2000, 100, fol(1)));
    for (int i = 0; i < 7; i++) tbl.push_back(mv(100, 100, 100, fol(1)));
    tbl.push_back(mv(100, 500, 100, fol(1)));
    for (int i = 0; i < 7; i++) tbl.push_back(mv(100, 100, 100, fol(1)));
    tbl.push_back(mv(100, 100, 100, st(1, 1)));
    tbl.push_back(mv(100, 100, 100, st(1, 1)));
    tbl.push_back(mv(500, 500, 500, st(1, 1)));
    tbl.push_back(mv(2000, 100, 100, fol(1)));

    repeat (2) @(negedge clk_50M);
    idle(st(0, 0), "reset_state");
    rst = 1'b0;
    enable = 1'b1;
    idle(st(0, 0), "idle_waits_sample");
    foreach (tbl[i]) smp(tbl[i].l, tbl[i].m, tbl[i].r, tbl[i].e, $sformatf("tbl[%0d]", i));

    exp_cnt = 4'd1;
    for (int i = 0; i < 16; i++) begin
      smp(2000, 2000, 2000, fol(exp_cnt), "wrap_on1");
      smp(2000, 2000, 2000, fol(exp_cnt), "wrap_on2");
      exp_cnt = exp_cnt + 4'd1;
      smp(2000, 2000, 2000, nd(exp_cnt, 1), $sformatf("wrap_node%0d", i));
      smp(100, 2000, 100, fol(exp_cnt), "wrap_exit");
    end

    smp(100, 500, 3000, tr(exp_cnt), "pre_disable_turn");
    enable = 1'b0;
    idle(st(exp_cnt, 0), "disable_mid_turn");
    enable = 1'b1;
    idle(st(exp_cnt, 0), "reenable_idle");
    smp(100, 2000, 100, fol(exp_cnt), "reenable_follow");
    smp(2000, 2000, 2000, fol(exp_cnt), "race_on1");
    smp(2000, 2000, 2000, fol(exp_cnt), "race_on2");
    enable = 1'b0;
    smp(2000, 2000, 2000, st(exp_cnt, 0), "race_enable_wins");
    enable = 1'b1;
    smp(2000, 2000, 2000, fol(exp_cnt), "deb_cleared_1");
    smp(2000, 2000, 2000, fol(exp_cnt), "deb_cleared_2");
    exp_cnt = exp_cnt + 4'd1;
    smp(2000, 2000, 2000, nd(exp_cnt, 1), "deb_cleared_node");
    smp(2000, 2000, 2000, nd(exp_cnt, 0), "node_hold");

    #3 rst = 1'b1;
    #1 sb.push_back(st(0, 0));
    check("async_reset_mid_node");
    @(negedge clk_50M);
    idle(st(0, 0), "reset_held");
    rst = 1'b0;
    idle(st(0, 0), "post_reset_idle");
    smp(100, 2000, 100, fol(0), "post_reset_follow");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/line_follower_fsm.md
# line_follower_fsm

Clocked, parametrised line-following controller for the three-sensor LFA front end. Each valid sample of left/middle/right is classified against thresholds, a registered FSM selects motor direction pins and PWM duty codes, node crossings are debounced and counted, and loss of line is detected with a timed stop. It sits between the ADC sampling block and the PWM/motor-driver block and replaces the earlier combinational follower.

## Interface
- ADC_W, 12, sensor sample width
- HI_THR, 1000, sample strictly above: sensor ON line
- LO_THR, 200, sample strictly below: sensor OFF line
- DC_W, 4, duty-code width
- NODE_W, 4, node counter width
- NODE_DEB, 3, consecutive all-ON samples required to declare a node (>=1)
- LOST_LIM, 8, consecutive all-OFF samples before LOST (>=1)
- DC_FWD, 4; DC_TURN_HI, 7; DC_TURN_LO, 3; DC_NODE_HI, 9; DC_NODE_LO, 5: duty codes

Ports:
- clk_50M  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run request; low forces IDLE
- sample_valid  in  1  one-cycle strobe: left/middle/right are new
- left, middle, right  in  ADC_W each  LFA samples
- m1_a, m1_b, m2_a, m2_b  out  1 each  motor direction pins (a=1,b=0 forward)
- dc1, dc2  out  DC_W each  left/right duty codes
- node_flag  out  1  high while in NODE state
- node_pulse  out  1  one-cycle strobe on node declaration
- node_count  out  NODE_W  nodes seen since reset
- lost_line  out  1  high while in LOST state

## Operation
- Classification per sensor: ON if >HI_THR, OFF if <LO_THR, else MID. Comparisons unsigned, full ADC_W.
- States: IDLE, FOLLOW, TURN_R, TURN_L, NODE, LOST. Transitions evaluated only on sample_valid (except enable/reset).
- IDLE: all motor pins 0, dc 0. enable=1 -> FOLLOW on next sample_valid.
- Priority on each sample in FOLLOW/TURN_R/TURN_L: (1) node debounce reached -> NODE; (2) lost limit reached -> LOST; (3) right ON & left OFF -> TURN_R; (4) left ON & right OFF -> TURN_L; (5) left OFF, middle ON, right OFF -> FOLLOW; (6) otherwise hold state.
- Outputs per state: FOLLOW m1=fwd, m2=fwd, dc1=dc2=DC_FWD. TURN_R m1 fwd, m2 rev, dc1=DC_TURN_HI, dc2=DC_TURN_LO. TURN_L m1 rev, m2 fwd, dc1=DC_TURN_LO, dc2=DC_TURN_HI. NODE m1 fwd, m2 rev, dc1=DC_NODE_HI, dc2=DC_NODE_LO. LOST/IDLE all pins 0, dc 0.
- Node debounce counter: increments on each sample with all three ON, clears on any other sample; saturates at NODE_DEB. Reaching NODE_DEB from FOLLOW/TURN_*: enter NODE, node_pulse=1, node_count+1 (wraps modulo 2^NODE_W).
- NODE exits only on pattern OFF-ON-OFF -> FOLLOW; all-ON samples while in NODE never re-count.
- Lost counter: increments on all-OFF samples, clears otherwise, saturates at LOST_LIM. In LOST, any sensor ON -> FOLLOW, counter cleared.
- enable low: next cycle IDLE, debounce/lost counters cleared, node_count held.

## Timing
- Reset values: state IDLE, all motor pins 0, dc1=dc2=0, node_flag=0, node_pulse=0, node_count=0, lost_line=0, counters 0.
- All outputs registered; latency one clk_50M cycle from sample_valid to updated outputs.
- node_pulse exactly one cycle, coincident with node_flag rising and node_count update.
- Simultaneous node-debounce completion and enable low: enable wins, no count.
- Reset mid-NODE: immediate return to reset values, no pulse.
- sample_valid back-to-back every cycle supported.

## Structure
- Package lf_pkg: state enum, sensor class enum (OFF/MID/ON), direction-pin constants.
- One sub-module: lf_sample_counter (saturating consecutive-event counter with clear), instantiated twice (node debounce, lost line).

## Test plan
- Reset then enable, samples (100,2000,100) -> FOLLOW: pins 1010, dc1=dc2=4 one cycle after sample_valid.
- Samples (100,500,3000) -> TURN_R: pins 1001, dc1=7, dc2=3; mirror (3000,500,100) -> TURN_L pins 0110, dc1=3, dc2=7.
- Two all-ON (2000,2000,2000) samples then one (100,2000,100) -> no node; three consecutive all-ON -> node_pulse once, node_count=1, dc 9/5; further all-ON no recount; OFF-ON-OFF -> FOLLOW.
- Sixteen node sequences with NODE_W=4 -> node_count wraps 15->0.
- Eight all-OFF samples -> LOST, pins 0, lost_line=1; sample (2000,100,100) -> FOLLOW.
- Assert rst mid-NODE -> all outputs at reset values asynchronously; deassert enable mid-TURN -> IDLE next cycle, node_count held.
